// File: rtl/spi_pkg.sv
// Types and constants shared by the SPI transaction arbiter and its sub-blocks.
package spi_pkg;

    localparam int SPI_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches from ptr+1 upward, wrapping, and
// returns the first requesting index as one-hot and binary.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         win,
    output logic [$clog2(NUM_REQ)-1:0] win_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        logic        found;
        int unsigned j;
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            j = (32'(ptr) + off) % NUM_REQ;
            if (!found && req[j[IDX_W-1:0]]) begin
                found                = 1'b1;
                win[j[IDX_W-1:0]]    = 1'b1;
                win_idx              = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin sequencer sharing one 16-bit SPI monarch among NUM_REQ clients:
// one command per grant, response routed back, then a fixed idle gap.
module spi_txn_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GAP_CYC = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [SPI_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       rsp_vld,
    output logic [SPI_W-1:0]         rsp_data,
    output logic                     busy,
    output logic                     spi_wrt,
    output logic [SPI_W-1:0]         spi_wt_data,
    input  logic                     spi_done,
    input  logic [SPI_W-1:0]         spi_rd_data
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   winner;
    logic [NUM_REQ-1:0] winner_oh;
    logic [GAP_W-1:0]   gap_cnt;
    logic [NUM_REQ-1:0] arb_win;
    logic [IDX_W-1:0]   arb_idx;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .win     (arb_win),
        .win_idx (arb_idx)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= IDX_W'(NUM_REQ - 1);
            winner      <= '0;
            winner_oh   <= '0;
            gap_cnt     <= '0;
            gnt         <= '0;
            rsp_vld     <= '0;
            rsp_data    <= '0;
            spi_wrt     <= 1'b0;
            spi_wt_data <= '0;
        end else begin
            gnt     <= '0;
            rsp_vld <= '0;
            spi_wrt <= 1'b0;
            case (state)
                IDLE: begin
                    // Grant and strobe are registered here so both show during ISSUE.
                    if (|req) begin
                        winner      <= arb_idx;
                        winner_oh   <= arb_win;
                        spi_wt_data <= req_data[SPI_W*int'(arb_idx) +: SPI_W];
                        gnt         <= arb_win;
                        spi_wrt     <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    ptr   <= winner;
                    state <= WAIT;
                end
                WAIT: begin
                    if (spi_done) begin
                        rsp_data <= spi_rd_data;
                        rsp_vld  <= winner_oh;
                        gap_cnt  <= '0;
                        state    <= (GAP_CYC == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
